// File: rtl/carregador_instrucoes.sv
// Boot loader: takes a framed byte stream (16-bit word count, little-endian program bytes,
// XOR checksum) and writes 32-bit words to instruction memory from word address 0.
// Latency: 4th byte of a word accepted at edge N -> mem_we high during cycle N+1.
// Backpressure: byte_pronto drops for the single write cycle and in both terminal states.
module carregador_instrucoes #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valido,
  input  logic [7:0]            byte_dado,
  output logic                  byte_pronto,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  reset_nucleo,
  output logic                  carga_ok,
  output logic                  erro,
  output logic [ADDR_WIDTH:0]   palavras_escritas
);

  typedef enum logic [2:0] {
    CONT_LO,
    CONT_HI,
    DADOS,
    ESCREVE,
    CHECK,
    CONCLUIDO,
    ERRO
  } estado_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  estado_t               estado_q, estado_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  byte_pronto_q, byte_pronto_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  reset_nucleo_q, reset_nucleo_d;
  logic                  carga_ok_q, carga_ok_d;
  logic                  erro_q, erro_d;

  logic                  transfer;
  logic [15:0]           count_novo;
  logic [15:0]           idx_prox;

  assign transfer = byte_valido & byte_pronto_q;
  // Full count as it will look once the high header byte is taken.
  assign count_novo = {byte_dado, count_q[7:0]};
  // Word index after the write in progress completes, widened for the count compare.
  assign idx_prox = 16'(idx_q) + 16'd1;

  // Next-state logic: frame parsing, word assembly, checksum and registered output decode.
  always_comb begin
    estado_d    = estado_q;
    count_d     = count_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (estado_q)
      CONT_LO: begin
        if (transfer) begin
          count_d[7:0] = byte_dado;
          estado_d     = CONT_HI;
        end
      end
      CONT_HI: begin
        if (transfer) begin
          count_d[15:8] = byte_dado;
          if (count_novo == 16'd0) begin
            estado_d = CHECK;
          end else if (count_novo > MAX_W) begin
            estado_d = ERRO;
          end else begin
            estado_d = DADOS;
          end
        end
      end
      DADOS: begin
        if (transfer) begin
          csum_d = csum_q ^ byte_dado;
          if (lane_q == 2'd3) begin
            // Last lane goes straight into the write data; the word register only holds lanes 0..2.
            lane_d      = 2'd0;
            mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
            mem_wdata_d = {byte_dado, word_q};
            estado_d    = ESCREVE;
          end else begin
            word_d[{lane_q, 3'b000} +: 8] = byte_dado;
            lane_d                        = lane_q + 2'd1;
          end
        end
      end
      ESCREVE: begin
        idx_d = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (idx_prox == count_q) begin
          estado_d = CHECK;
        end else begin
          estado_d = DADOS;
        end
      end
      CHECK: begin
        if (transfer) begin
          estado_d = (byte_dado == csum_q) ? CONCLUIDO : ERRO;
        end
      end
      default: begin
        estado_d = estado_q;
      end
    endcase

    // Outputs are decoded from the next state so they are registered without extra lag.
    byte_pronto_d  = (estado_d == CONT_LO) || (estado_d == CONT_HI) ||
                     (estado_d == DADOS)   || (estado_d == CHECK);
    mem_we_d       = (estado_d == ESCREVE);
    reset_nucleo_d = (estado_d != CONCLUIDO);
    carga_ok_d     = (estado_d == CONCLUIDO);
    erro_d         = (estado_d == ERRO);
  end

  // State and output registers; asynchronous reset restores the idle, core-held-in-reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q       <= CONT_LO;
      count_q        <= 16'd0;
      idx_q          <= '0;
      lane_q         <= 2'd0;
      word_q         <= 24'd0;
      csum_q         <= 8'd0;
      byte_pronto_q  <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
      reset_nucleo_q <= 1'b1;
      carga_ok_q     <= 1'b0;
      erro_q         <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      lane_q         <= lane_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      byte_pronto_q  <= byte_pronto_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      reset_nucleo_q <= reset_nucleo_d;
      carga_ok_q     <= carga_ok_d;
      erro_q         <= erro_d;
    end
  end

  assign byte_pronto       = byte_pronto_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign reset_nucleo      = reset_nucleo_q;
  assign carga_ok          = carga_ok_q;
  assign erro              = erro_q;
  assign palavras_escritas = idx_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Bench for the instruction loader: builds frames, predicts the write sequence and final
// status from the frame contents, and checks every write cycle plus the end-of-frame outputs.
module tb_carregador_instrucoes;

  localparam int AW = 8;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          byte_valido;
  logic [7:0]    byte_dado;
  logic          byte_pronto;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          reset_nucleo;
  logic          carga_ok;
  logic          erro;
  logic [AW:0]   palavras_escritas;

  int tests = 0;
  int fails = 0;

  logic [39:0] exp_q[$];         // expected writes: {addr, data}
  logic [31:0] tb_mem [0:255];   // memory as written by the DUT
  logic [31:0] words  [0:255];   // program words of the frame being sent

  carregador_instrucoes #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk               (clk),
    .reset             (reset),
    .byte_valido       (byte_valido),
    .byte_dado         (byte_dado),
    .byte_pronto       (byte_pronto),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .reset_nucleo      (reset_nucleo),
    .carga_ok          (carga_ok),
    .erro              (erro),
    .palavras_escritas (palavras_escritas)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Write monitor: every mem_we cycle must match the next predicted write.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!reset && mem_we) begin
        check("we_pronto_low", {31'd0, byte_pronto}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
          check("write_data", mem_wdata, e[31:0]);
        end
        tb_mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Offer one byte (after a random idle gap) and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gapmax, input bit fourth);
    int g;
    int n;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (g) begin
      @(negedge clk);
      byte_valido = 1'b0;
      byte_dado   = 8'($urandom);
    end
    @(negedge clk);
    byte_valido = 1'b1;
    byte_dado   = b;
    n = 0;
    while (!byte_pronto && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: byte_pronto 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    if (fourth) check("we_latency", {31'd0, mem_we}, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b1;
    byte_valido = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Send a complete frame and check the predicted outcome.
  task automatic do_frame(input int n, input bit rnd_words, input bit force_cs,
                          input logic [7:0] cs_val, input int gapmax);
    logic [7:0] cs;
    logic [7:0] csb;
    bit         ok;
    cs = 8'd0;
    if (rnd_words)
      for (int i = 0; i < 256; i++) words[i] = $urandom;
    send_byte(8'(n), gapmax, 1'b0);
    send_byte(8'(n >> 8), gapmax, 1'b0);
    if (n > MW) begin
      @(negedge clk);
      check("oversize_erro", {31'd0, erro}, 32'd1);
      check("oversize_pronto", {31'd0, byte_pronto}, 32'd0);
      check("oversize_words", 32'(palavras_escritas), 32'd0);
      byte_valido = 1'b1;
      byte_dado   = 8'hAB;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("erro_no_accept", {31'd0, byte_pronto}, 32'd0);
      end
      byte_valido = 1'b0;
      check("oversize_erro_hold", {31'd0, erro}, 32'd1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), words[i]});
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w  = words[i];
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], gapmax, k == 3);
      end
    end
    csb = force_cs ? cs_val : cs;
    ok  = (csb == cs);
    send_byte(csb, gapmax, 1'b0);
    @(negedge clk);
    byte_valido = 1'b0;
    check("carga_ok", {31'd0, carga_ok}, {31'd0, ok});
    check("erro", {31'd0, erro}, {31'd0, !ok});
    check("reset_nucleo", {31'd0, reset_nucleo}, {31'd0, !ok});
    check("palavras", 32'(palavras_escritas), 32'(n));
    check("pronto_final", {31'd0, byte_pronto}, 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    byte_valido = 1'b0;
    byte_dado   = 8'd0;
    #12;
    check("rst_pronto", {31'd0, byte_pronto}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_nucleo", {31'd0, reset_nucleo}, 32'd1);
    check("rst_ok", {31'd0, carga_ok}, 32'd0);
    check("rst_erro", {31'd0, erro}, 32'd0);
    check("rst_words", 32'(palavras_escritas), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Two-instruction program; 0x10 is the XOR of its eight data bytes.
    words[0] = 32'h00A00513;
    words[1] = 32'h00300593;
    do_frame(2, 1'b0, 1'b1, 8'h10, 0);
    check("lit_mem0", tb_mem[0], 32'h00A00513);
    check("lit_mem1", tb_mem[1], 32'h00300593);
    check("lit_ok", {31'd0, carga_ok}, 32'd1);

    apply_reset();
    do_frame(2, 1'b0, 1'b1, 8'h00, 0);
    check("lit_bad_erro", {31'd0, erro}, 32'd1);
    apply_reset();
    do_frame(2, 1'b0, 1'b1, 8'h95, 1);

    apply_reset();
    do_frame(0, 1'b1, 1'b1, 8'h00, 0);
    check("empty_ok", {31'd0, carga_ok}, 32'd1);
    apply_reset();
    do_frame(0, 1'b1, 1'b1, 8'h01, 0);
    check("empty_bad", {31'd0, erro}, 32'd1);

    apply_reset();
    do_frame(257, 1'b1, 1'b0, 8'h00, 0);
    apply_reset();
    do_frame(256, 1'b1, 1'b0, 8'h00, 0);
    check("max_last", tb_mem[255], words[255]);

    for (int f = 0; f < 8; f++) begin
      apply_reset();
      do_frame(int'($urandom_range(1, 20)), 1'b1, ($urandom_range(0, 3) == 0),
               8'($urandom), int'($urandom_range(0, 4)));
    end

    // Asynchronous reset in the middle of word 1.
    apply_reset();
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    send_byte(8'd3, 0, 1'b0);
    send_byte(8'd0, 0, 1'b0);
    exp_q.push_back({8'd0, words[0]});
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 0, k == 3);
    send_byte(words[1][7:0], 0, 1'b0);
    send_byte(words[1][15:8], 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_pronto", {31'd0, byte_pronto}, 32'd1);
    check("mid_we", {31'd0, mem_we}, 32'd0);
    check("mid_addr", {24'd0, mem_addr}, 32'd0);
    check("mid_wdata", mem_wdata, 32'd0);
    check("mid_nucleo", {31'd0, reset_nucleo}, 32'd1);
    check("mid_ok", {31'd0, carga_ok}, 32'd0);
    check("mid_words", 32'(palavras_escritas), 32'd0);
    check("mid_word0_written", 32'(exp_q.size()), 32'd0);
    byte_valido = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_frame(3, 1'b1, 1'b0, 8'h00, 2);
    check("reload_mem0", tb_mem[0], words[0]);
    check("reload_mem2", tb_mem[2], words[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
